// File: rtl/vram_arbiter_if.sv
// Bundles the scanout port, both writer ports, vblank and the video RAM port of vram_arbiter.
// The master modport is the arbiter's view; the slave modport is the requester/RAM view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_rvalid;

  logic              wr0_req;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_gnt;

  logic              wr1_req;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_gnt;

  logic              vblank;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  scan_req, scan_addr,
    output scan_rdata, scan_rvalid,
    input  wr0_req, wr0_addr, wr0_data,
    output wr0_gnt,
    input  wr1_req, wr1_addr, wr1_data,
    output wr1_gnt,
    input  vblank,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    output scan_req, scan_addr,
    input  scan_rdata, scan_rvalid,
    output wr0_req, wr0_addr, wr0_data,
    input  wr0_gnt,
    output wr1_req, wr1_addr, wr1_data,
    input  wr1_gnt,
    output vblank,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scanout reads win outright, two writers share the rest round-robin.
// Define VRAM_ARB_VBLANK_ONLY_EN to confine writes to vertical blanking.
module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic           pixel_clk,
  input logic           reset,
  vram_arbiter_if.master bus
);

  localparam int NW = 2;

  logic [NW-1:0]     wr_req;
  logic [ADDR_W-1:0] wr_addr [NW];
  logic [DATA_W-1:0] wr_data [NW];

  assign wr_req     = {bus.wr1_req, bus.wr0_req};
  assign wr_addr[0] = bus.wr0_addr;
  assign wr_addr[1] = bus.wr1_addr;
  assign wr_data[0] = bus.wr0_data;
  assign wr_data[1] = bus.wr1_data;

  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              mem_we_reg, mem_we_next;
  logic              mem_re_reg, mem_re_next;
  logic              rvalid_reg;
  logic [NW-1:0]     gnt_reg, gnt_next;
  logic              last_reg, last_next;

  logic              write_window;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
  assign write_window = bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign write_window  = 1'b1;
`endif

  // A writer already showing gnt is holding the request it just had served.
  logic [NW-1:0] eligible;
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_elig
      assign eligible[gi] = wr_req[gi] & ~gnt_reg[gi] & write_window;
    end
  endgenerate

  logic win_valid;
  logic win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 1'b0;
    case (eligible)
      2'b01: begin
        win_valid = 1'b1;
        win_idx   = 1'b0;
      end
      2'b10: begin
        win_valid = 1'b1;
        win_idx   = 1'b1;
      end
      2'b11: begin
        win_valid = 1'b1;
        win_idx   = ~last_reg;
      end
      default: begin
        win_valid = 1'b0;
        win_idx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    gnt_next       = '0;
    last_next      = last_reg;
    if (bus.scan_req) begin
      mem_re_next   = 1'b1;
      mem_addr_next = bus.scan_addr;
    end else if (win_valid) begin
      mem_we_next       = 1'b1;
      mem_addr_next     = wr_addr[win_idx];
      mem_wdata_next    = wr_data[win_idx];
      gnt_next[win_idx] = 1'b1;
      last_next         = win_idx;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      rvalid_reg    <= 1'b0;
      gnt_reg       <= '0;
      last_reg      <= 1'b1;
    end else begin
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      mem_re_reg    <= mem_re_next;
      rvalid_reg    <= mem_re_reg;
      gnt_reg       <= gnt_next;
      last_reg      <= last_next;
    end
  end

  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_re      = mem_re_reg;
  assign bus.wr0_gnt     = gnt_reg[0];
  assign bus.wr1_gnt     = gnt_reg[1];
  assign bus.scan_rdata  = bus.mem_rdata;
  assign bus.scan_rvalid = rvalid_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a per-cycle reference model queues expected RAM operations,
// grants and read data; an independent monitor compares them against the DUT on the falling edge.
module tb_vram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RAM_N  = 1024;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
  localparam bit VB_ONLY = 1'b1;
  localparam int VB_GNT  = 11;
`else
  localparam bit VB_ONLY = 1'b0;
  localparam int VB_GNT  = 1;
`endif

  logic pixel_clk = 1'b0;
  logic reset = 1'b1;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Behavioural RAM: untouched words read back as addr - 0x60 (0x100 -> 0xA0).
  logic [DATA_W-1:0] ram [RAM_N];
  logic [RAM_N-1:0]  ram_wr = '0;
  logic [DATA_W-1:0] ram_q;
  assign bus.mem_rdata = ram_q;
  always @(posedge pixel_clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr[9:0]]    <= bus.mem_wdata;
      ram_wr[bus.mem_addr[9:0]] <= 1'b1;
    end
    if (bus.mem_re)
      ram_q <= ram_wr[bus.mem_addr[9:0]] ? ram[bus.mem_addr[9:0]] : bus.mem_addr - 16'h0060;
  end

  typedef struct packed {
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        g0;
    logic        g1;
    logic        rvalid;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Stimulus variables
  logic        t_scan_req = 1'b0;
  logic [15:0] t_scan_addr = '0;
  logic        t_vblank = 1'b0;
  logic        w_req [2] = '{1'b0, 1'b0};
  logic [15:0] w_addr [2] = '{16'h0, 16'h0};
  logic [15:0] w_data [2] = '{16'h0, 16'h0};
  bit          fresh [2] = '{1'b0, 1'b0};

  // Reference model state
  logic [15:0] golden [logic [15:0]];
  logic [1:0]  m_g = '0;
  int          m_last = 1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic        m_re = 1'b0;
  logic [15:0] m_pend = '0;

  function automatic logic [15:0] gold_rd(input logic [15:0] a);
    if (golden.exists(a)) return golden[a];
    return a - 16'h0060;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
  endtask

  task automatic apply();
    bus.scan_req  = t_scan_req;
    bus.scan_addr = t_scan_addr;
    bus.vblank    = t_vblank;
    bus.wr0_req   = w_req[0];
    bus.wr0_addr  = w_addr[0];
    bus.wr0_data  = w_data[0];
    bus.wr1_req   = w_req[1];
    bus.wr1_addr  = w_addr[1];
    bus.wr1_data  = w_data[1];
  endtask

  // Drives this cycle's inputs, predicts the next cycle's outputs, then advances one clock.
  task automatic step();
    exp_t       e;
    logic [1:0] el;
    int         pick;
    apply();
    e    = '0;
    el   = '0;
    pick = -1;
    if (reset) begin
      m_g = '0; m_last = 1; m_addr = '0; m_wdata = '0; m_re = 1'b0;
    end else begin
      e.rvalid = m_re;
      if (m_re) rd_q.push_back(m_pend);
      for (int k = 0; k < 2; k++)
        el[k] = w_req[k] && !m_g[k] && (!VB_ONLY || t_vblank);
      if (t_scan_req) begin
        m_addr = t_scan_addr;
        m_pend = gold_rd(t_scan_addr);
      end else if (el == 2'b11) pick = 1 - m_last;
      else if (el[0]) pick = 0;
      else if (el[1]) pick = 1;
      if (pick >= 0) begin
        m_addr  = w_addr[pick];
        m_wdata = w_data[pick];
        golden[m_addr] = m_wdata;
        m_last  = pick;
      end
      m_re    = t_scan_req;
      m_g[0]  = (pick == 0);
      m_g[1]  = (pick == 1);
      e.re    = t_scan_req;
      e.we    = (pick >= 0);
    end
    e.addr  = m_addr;
    e.wdata = m_wdata;
    e.g0    = m_g[0];
    e.g1    = m_g[1];
    exp_q.push_back(e);
    @(posedge pixel_clk);
    #1;
    cyc++;
  endtask

  // Writers hold until they see gnt, keep values in the gnt cycle, then choose afresh.
  task automatic auto_writers(input int p0, input int p1);
    logic g;
    int   p;
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? bus.wr0_gnt : bus.wr1_gnt;
      p = (k == 0) ? p0 : p1;
      if (g) fresh[k] = 1'b1;
      else if (fresh[k] || !w_req[k]) begin
        fresh[k]  = 1'b0;
        w_req[k]  = (int'($urandom_range(0, 99)) < p);
        w_addr[k] = 16'($urandom_range(0, 31));
        w_data[k] = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    t_scan_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_req[k] = 1'b0;
      fresh[k] = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [15:0] d;
    forever begin
      @(negedge pixel_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_re", 32'(bus.mem_re), 32'(e.re));
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (!e.re) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
        chk("gnt", 32'({bus.wr1_gnt, bus.wr0_gnt}), 32'({e.g1, e.g0}));
        chk("scan_rvalid", 32'(bus.scan_rvalid), 32'(e.rvalid));
        chk("we_re_excl", 32'(bus.mem_we & bus.mem_re), 32'(0));
        if (e.rvalid && rd_q.size() > 0) begin
          d = rd_q.pop_front();
          if (bus.scan_rvalid) chk("scan_rdata", 32'(bus.scan_rdata), 32'(d));
        end
        if (bus.mem_we)
          $display("cycle %0d: write addr=0x%04h data=0x%04h gnt=%b%b",
                   cyc, bus.mem_addr, bus.mem_wdata, bus.wr1_gnt, bus.wr0_gnt);
        if (bus.scan_rvalid)
          $display("cycle %0d: read data=0x%04h", cyc, bus.scan_rdata);
      end
    end
  end

  initial begin
    int  scan_left;
    int  vb_left;
    bit  gseen;

    // Reset held with wr0 and scan requesting: everything stays quiet.
    t_vblank = 1'b1;
    w_req[0] = 1'b1; w_addr[0] = 16'h0030; w_data[0] = 16'h3333;
    t_scan_req = 1'b1; t_scan_addr = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_ctl", 32'({bus.mem_re, bus.mem_we, bus.wr0_gnt, bus.wr1_gnt, bus.scan_rvalid}), 32'(0));
      chk("rst_addr", 32'(bus.mem_addr), 32'(0));
      chk("rst_wdata", 32'(bus.mem_wdata), 32'(0));
    end
    reset = 1'b0;
    step();
    chk("rel_re", 32'(bus.mem_re), 32'(1));
    chk("rel_addr", 32'(bus.mem_addr), 32'h0005);
    t_scan_req = 1'b0;
    step();
    chk("rel_g0", 32'(bus.wr0_gnt), 32'(1));
    chk("rel_waddr", 32'(bus.mem_addr), 32'h0030);
    step();
    chk("rel_nodouble", 32'(bus.wr0_gnt), 32'(0));
    w_req[0] = 1'b0;
    step();

    // Back-to-back reads, data two cycles later.
    do_reset();
    t_scan_req = 1'b1; t_scan_addr = 16'h0100;
    step();
    t_scan_addr = 16'h0101;
    step();
    chk("burst_v0", 32'(bus.scan_rvalid), 32'(1));
    chk("burst_d0", 32'(bus.scan_rdata), 32'h00A0);
    t_scan_addr = 16'h0102;
    step();
    chk("burst_d1", 32'(bus.scan_rdata), 32'h00A1);
    t_scan_req = 1'b0;
    step();
    chk("burst_d2", 32'(bus.scan_rdata), 32'h00A2);
    step();
    chk("burst_end", 32'(bus.scan_rvalid), 32'(0));

    // Both writers held from cycle 0.
    do_reset();
    w_req[0] = 1'b1; w_addr[0] = 16'h0010; w_data[0] = 16'h1111;
    w_req[1] = 1'b1; w_addr[1] = 16'h0020; w_data[1] = 16'h2222;
    step();
    chk("tie_g", 32'({bus.wr1_gnt, bus.wr0_gnt}), 32'(2'b01));
    chk("tie_a0", 32'(bus.mem_addr), 32'h0010);
    step();
    chk("tie_g2", 32'({bus.wr1_gnt, bus.wr0_gnt}), 32'(2'b10));
    chk("tie_a1", 32'(bus.mem_addr), 32'h0020);
    chk("tie_we", 32'(bus.mem_we), 32'(1));
    w_req[0] = 1'b0;
    step();
    chk("tie_nodouble", 32'({bus.wr1_gnt, bus.wr0_gnt, bus.mem_we}), 32'(0));
    w_req[1] = 1'b0;
    step();

    // Continuous requests from both writers alternate and fill every cycle.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      auto_writers(100, 100);
      step();
      chk("alt_we", 32'(bus.mem_we), 32'(1));
      chk("alt_g", 32'({bus.wr1_gnt, bus.wr0_gnt}), (c % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
    end

    // Scan pulses in cycles 3 and 5 against a busy writer 0.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      t_scan_req  = (c == 3 || c == 5);
      t_scan_addr = 16'(16'h0040 + c);
      auto_writers(100, 0);
      step();
      chk("pulse_re", 32'(bus.mem_re), 32'((c + 1 == 4) || (c + 1 == 6)));
      chk("pulse_g0", 32'(bus.wr0_gnt), 32'((c + 1) % 2 == 1));
    end
    t_scan_req = 1'b0;

    // Writer 1 against a vblank that rises in cycle 10.
    do_reset();
    gseen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin
        w_req[1] = 1'b1; w_addr[1] = 16'h0050; w_data[1] = 16'h5555;
      end else begin
        chk("vb_g1", 32'(bus.wr1_gnt), 32'(c == VB_GNT));
        if (gseen) w_req[1] = 1'b0;
        if (bus.wr1_gnt) gseen = 1'b1;
      end
      t_vblank = (c >= 10);
      step();
    end

    // Random traffic with occasional resets.
    do_reset();
    scan_left = 0;
    vb_left   = 0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (scan_left > 0) begin
        t_scan_req = 1'b1;
        scan_left--;
      end else if ($urandom_range(0, 99) < 20) begin
        t_scan_req = 1'b1;
        scan_left  = int'($urandom_range(0, 6));
      end else t_scan_req = 1'b0;
      t_scan_addr = 16'($urandom_range(0, 31));
      if (vb_left == 0) begin
        t_vblank = ~t_vblank;
        vb_left  = int'($urandom_range(5, 40));
      end else vb_left--;
      auto_writers(60, 60);
      step();
    end

    reset = 1'b0;
    t_scan_req = 1'b0;
    w_req[0] = 1'b0;
    w_req[1] = 1'b0;
    repeat (3) step();
    @(negedge pixel_clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
